// File: rtl/gon_bus.sv
// gon_bus: gathers NUMS_SLAVE tagged source ports onto one master stream through a 2-entry FIFO
//   Parameters: NUMS_SLAVE sources, ID_SIZE id/tag width; data width is `DATA_BITS.
//   Ports: clk, rst (async, active-high); tag selects the source id the master reads from;
//          slave_valid/slave_data/slave_ready per source; master_valid/master_data/master_ready
//          output stream; set_id/ID_scan_in/ID_scan_out id scan chain; err_multi sticky collision flag.
//   Macro GON_COLLISION_CHECK_EN enables multi-match detection on err_multi (tied to 0 otherwise).
`ifndef DATA_BITS
`define DATA_BITS 8
`endif
`ifndef XID_BITS
`define XID_BITS 4
`endif
`ifndef NUMS_PE_COL
`define NUMS_PE_COL 4
`endif
module gon_bus #(
    parameter int NUMS_SLAVE = `NUMS_PE_COL,
    parameter int ID_SIZE    = `XID_BITS
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ID_SIZE-1:0]               tag,
    input  logic [NUMS_SLAVE-1:0]            slave_valid,
    input  logic [NUMS_SLAVE*`DATA_BITS-1:0] slave_data,
    output logic [NUMS_SLAVE-1:0]            slave_ready,
    output logic                             master_valid,
    output logic [`DATA_BITS-1:0]            master_data,
    input  logic                             master_ready,
    input  logic                             set_id,
    input  logic [ID_SIZE-1:0]               ID_scan_in,
    output logic [ID_SIZE-1:0]               ID_scan_out,
    output logic                             err_multi
);
    localparam int DW = `DATA_BITS;
    logic [ID_SIZE-1:0]    id_q [NUMS_SLAVE];
    logic [NUMS_SLAVE-1:0] hit, sel;
    logic [DW-1:0]         mem_q [2];
    logic [DW-1:0]         push_data;
    logic                  wr_q, rd_q, push, pop;
    logic [1:0]            cnt_q, cnt_d;
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUMS_SLAVE; i++) hit[i] = (id_q[i] == tag) && slave_valid[i];
    end
    // Two's-complement trick isolates the lowest set bit: lowest-index source wins.
    assign sel = hit & (~hit + 1'b1);
    // Readiness looks only at the registered count, so a full FIFO never bypasses on a pop.
    assign slave_ready  = (!set_id && cnt_q != 2'd2) ? sel : '0;
    assign push         = |slave_ready;
    assign pop          = master_valid && master_ready;
    assign master_valid = cnt_q != 2'd0;
    assign master_data  = mem_q[rd_q];
    assign ID_scan_out  = id_q[NUMS_SLAVE-1];
    assign cnt_d        = cnt_q + {1'b0, push} - {1'b0, pop};
    always_comb begin
        push_data = '0;
        for (int i = 0; i < NUMS_SLAVE; i++) push_data = push_data | (sel[i] ? slave_data[i*DW +: DW] : '0);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUMS_SLAVE; i++) id_q[i] <= '0;
        end else if (set_id) begin
            id_q[0] <= ID_scan_in;
            for (int i = 1; i < NUMS_SLAVE; i++) id_q[i] <= id_q[i-1];
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= push_data;
                wr_q        <= ~wr_q;
            end
            if (pop) rd_q <= ~rd_q;
            cnt_q <= cnt_d;
        end
    end
`ifdef GON_COLLISION_CHECK_EN
    logic err_q;
    // hit & (hit-1) is nonzero exactly when more than one bit is set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else if (!set_id && (hit & (hit - 1'b1)) != '0) err_q <= 1'b1;
    end
    assign err_multi = err_q;
`else
    assign err_multi = 1'b0;
`endif
endmodule

// File: tb/tb_gon_bus.sv
// tb_gon_bus: directed scoreboard bench for gon_bus (4 sources, 4-bit ids, 8-bit data)
`ifndef DATA_BITS
`define DATA_BITS 8
`endif
module tb_gon_bus;
    localparam int NS = 4;
    localparam int IW = 4;
    localparam int DW = `DATA_BITS;
`ifdef GON_COLLISION_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [IW-1:0]    tag = '0;
    logic [NS-1:0]    slave_valid = '0;
    logic [NS*DW-1:0] slave_data = '0;
    logic [NS-1:0]    slave_ready;
    logic             master_valid;
    logic [DW-1:0]    master_data;
    logic             master_ready = 1'b0;
    logic             set_id = 1'b0;
    logic [IW-1:0]    ID_scan_in = '0;
    logic [IW-1:0]    ID_scan_out;
    logic             err_multi;
    int               checks = 0;
    int               failures = 0;
    logic [DW-1:0]    sb[$];
    gon_bus #(.NUMS_SLAVE(NS), .ID_SIZE(IW)) dut (
        .clk(clk), .rst(rst), .tag(tag), .slave_valid(slave_valid), .slave_data(slave_data),
        .slave_ready(slave_ready), .master_valid(master_valid), .master_data(master_data),
        .master_ready(master_ready), .set_id(set_id), .ID_scan_in(ID_scan_in),
        .ID_scan_out(ID_scan_out), .err_multi(err_multi)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic settle();
        #3;
    endtask
    task automatic chk_head(input string name);
        chk({name, "_valid"}, {31'b0, master_valid}, 32'd1);
        if (sb.size() == 0) chk({name, "_sb_empty"}, 32'd0, 32'd1);
        else chk({name, "_data"}, {24'b0, master_data}, {24'b0, sb[0]});
    endtask
    task automatic set_src(input int s, input logic [DW-1:0] d);
        slave_data[s*DW +: DW] = d;
    endtask
    initial begin
        #2;
        chk("rst_mvalid", {31'b0, master_valid}, 32'd0);
        chk("rst_sready", {28'b0, slave_ready}, 32'd0);
        chk("rst_err", {31'b0, err_multi}, 32'd0);
        chk("rst_scan_out", {28'b0, ID_scan_out}, 32'd0);
        #4 rst = 1'b0;
        step();
        set_id = 1'b1;
        slave_valid = 4'hF;
        for (int k = 0; k < 4; k++) begin
            ID_scan_in = IW'(3 - k);
            settle();
            chk("scan_sready_blocked", {28'b0, slave_ready}, 32'd0);
            step();
        end
        set_id = 1'b0;
        slave_valid = '0;
        settle();
        chk("scan_out", {28'b0, ID_scan_out}, 32'd3);
        chk("scan_err", {31'b0, err_multi}, 32'd0);
        tag = 4'd2;
        slave_valid = 4'b0100;
        set_src(2, 8'h55);
        settle();
        chk("single_sready", {28'b0, slave_ready}, 32'b0100);
        sb.push_back(8'h55);
        step();
        slave_valid = '0;
        settle();
        chk_head("single_head");
        master_ready = 1'b1;
        step();
        void'(sb.pop_front());
        master_ready = 1'b0;
        settle();
        chk("single_drained", {31'b0, master_valid}, 32'd0);
        for (int t = 0; t < 4; t++) begin
            tag = IW'(t);
            slave_valid = 4'hF;
            for (int s = 0; s < 4; s++) set_src(s, DW'(8'h10 + 8'(s)));
            settle();
            chk("route_sready", {28'b0, slave_ready}, 32'd1 << t);
            sb.push_back(DW'(8'h10 + 8'(t)));
            step();
            slave_valid = '0;
            master_ready = 1'b1;
            settle();
            chk_head("route_head");
            step();
            void'(sb.pop_front());
            master_ready = 1'b0;
        end
        tag = 4'd2;
        slave_valid = 4'b0100;
        for (int k = 1; k <= 3; k++) begin
            set_src(2, DW'(k));
            settle();
            chk("full_sready", {28'b0, slave_ready}, k < 3 ? 32'b0100 : 32'd0);
            if (k < 3) sb.push_back(DW'(k));
            step();
        end
        master_ready = 1'b1;
        settle();
        chk("full_no_bypass", {28'b0, slave_ready}, 32'd0);
        chk_head("full_head1");
        step();
        void'(sb.pop_front());
        slave_valid = '0;
        settle();
        chk_head("full_head2");
        step();
        void'(sb.pop_front());
        master_ready = 1'b0;
        settle();
        chk("full_drained", {31'b0, master_valid}, 32'd0);
        slave_valid = 4'b0100;
        set_src(2, 8'h07);
        sb.push_back(8'h07);
        step();
        set_src(2, 8'h0A);
        master_ready = 1'b1;
        settle();
        chk("pp_sready", {28'b0, slave_ready}, 32'b0100);
        chk_head("pp_head_before");
        sb.push_back(8'h0A);
        step();
        void'(sb.pop_front());
        slave_valid = '0;
        settle();
        chk_head("pp_head_after");
        step();
        void'(sb.pop_front());
        master_ready = 1'b0;
        settle();
        chk("pp_count1", {31'b0, master_valid}, 32'd0);
        set_id = 1'b1;
        ID_scan_in = 4'd5;
        repeat (4) step();
        set_id = 1'b0;
        tag = 4'd5;
        slave_valid = 4'b1010;
        set_src(1, 8'hB1);
        set_src(3, 8'hB3);
        settle();
        chk("multi_sready", {28'b0, slave_ready}, 32'b0010);
        sb.push_back(8'hB1);
        step();
        settle();
        chk("multi_err", {31'b0, err_multi}, {31'b0, EXP_ERR});
        chk_head("multi_head");
        sb.push_back(8'hB1);
        step();
        slave_valid = '0;
        settle();
        chk("prerst_sready_full", {28'b0, slave_ready}, 32'd0);
        rst = 1'b1;
        #1;
        sb.delete();
        chk("arst_mvalid", {31'b0, master_valid}, 32'd0);
        chk("arst_err", {31'b0, err_multi}, 32'd0);
        chk("arst_scan_out", {28'b0, ID_scan_out}, 32'd0);
        #2 rst = 1'b0;
        step();
        settle();
        chk("postrst_empty", {31'b0, master_valid}, 32'd0);
        tag = 4'd0;
        slave_valid = 4'b0001;
        set_src(0, 8'hC0);
        settle();
        chk("postrst_ids_zero", {28'b0, slave_ready}, 32'b0001);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
